sprite_rom_arbiter: RTL and testbench
=====================================

# sprite_rom_arbiter

Shares one sprite-image ROM between `N_REQ` sprite-drawing requesters that each issue a read strobe and a per-sprite pixel address every pixel clock. Each requester has its own image base in the shared ROM. Every cycle, fixed priority selects one requester (lowest index wins), forms the ROM address, and routes the returned data back after the ROM latency. Losing requesters receive `TRANSPARENT`, so they draw nothing for that pixel. The block sits between the sprite draw stages and the single ROM, and it also reports a per-frame contention count.

## Interface

Parameters:
- `N_REQ`, 4: number of requesters.
- `ADDR_W`, 19: width of each requester's pixel address (clog2(640*480)).
- `ROM_ADDR_W`, 16: shared ROM address width.
- `DATA_W`, 12: pixel data width, packed RGB444.
- `ROM_LATENCY`, 2: cycles from `rom_addr` presented to `rom_data` valid; must be ≥1.
- `TRANSPARENT`, 12'h000: data returned to requesters that were not granted or did not read.

Ports:
- `clk`, in, 1: pixel clock.
- `resetN`, in, 1: asynchronous, active-low reset.
- `frame_start`, in, 1: one-cycle pulse at the start of each frame.
- `req_en`, in, `N_REQ`: configuration mask; a requester with its bit at 0 is ignored.
- `base_addr`, in, `N_REQ*ROM_ADDR_W`: per-requester image base; requester i uses slice [i*ROM_ADDR_W +: ROM_ADDR_W].
- `req_rd`, in, `N_REQ`: per-requester read strobe (the requester's in-rectangle signal).
- `req_addr`, in, `N_REQ*ADDR_W`: per-requester pixel offset within its image.
- `req_data`, out, `N_REQ*DATA_W`: per-requester returned pixel.
- `rom_rd`, out, 1: read strobe to the ROM.
- `rom_addr`, out, `ROM_ADDR_W`: address to the ROM.
- `rom_data`, in, `DATA_W`: ROM output.
- `grant_idx`, out, clog2(`N_REQ`): index of the current-cycle winner; 0 when there is no winner.
- `conflict_count`, out, 16: number of contention cycles in the previous frame.
- `conflict_valid`, out, 1: one-cycle pulse when `conflict_count` updates.

## Operation

Arbitration (combinational, same cycle):
- Active set: `act = req_rd & req_en`.
- Winner: the lowest index i with `act[i]` = 1. `gnt_vec` is the one-hot of the winner, or all-zero if `act` = 0.
- `rom_rd` = |act.
- `rom_addr` = `base_addr[i] + req_addr[i][ROM_ADDR_W-1:0]`, modulo 2^ROM_ADDR_W (wrap, no saturation). It is 0 when there is no winner.
- `grant_idx` = i, or 0 when there is no winner.

Return path (sequential):
- A shift register of `ROM_LATENCY` stages carries `gnt_vec`.
- Stage output `gnt_d` aligns with `rom_data`.
- `req_data[i]` = `rom_data` when `gnt_d[i]` = 1, otherwise `TRANSPARENT`.
- Outcome for each requester, for every cycle t:
  - Granted at t: sees ROM data at t+`ROM_LATENCY`, identical to owning a private ROM.
  - Not granted at t (lost, masked, or no read): sees `TRANSPARENT` at t+`ROM_LATENCY`.

Contention statistics:
- A conflict cycle is any cycle with popcount(act) ≥ 2. Each conflict cycle counts once, however many requesters collide.
- The running counter `cnt` is 16 bits and saturates at 16'hFFFF.
- On `frame_start`: `conflict_count` <= `cnt`, `conflict_valid` <= 1, and `cnt` restarts.
  - `cnt` <= 1 if the `frame_start` cycle is itself a conflict, else 0.
  - The `frame_start` cycle therefore belongs to the new frame.
- `conflict_valid` is 0 in every cycle not immediately following `frame_start`.

Configuration:
- `req_en` and `base_addr` may change at any time and take effect in the same cycle.
- Reads already in flight keep their original routing.

Reset (asynchronous, `resetN` = 0):
- Grant pipeline clears to all-zero, so `req_data` = `TRANSPARENT` on every port.
- `cnt` = 0, `conflict_count` = 0, `conflict_valid` = 0.
- `rom_rd`, `rom_addr` and `grant_idx` follow inputs combinationally; they are 0 whenever `req_rd` = 0.
- Reset asserted mid-flight discards all pending grants. No stale data is delivered after release.

## Timing

- Arbiter-to-ROM path: 0 cycles, combinational.
- Data return: exactly `ROM_LATENCY` cycles after the request cycle.
- Full throughput: one grant per cycle, no back-pressure, no stalls.
- `conflict_count` and `conflict_valid` update on the clock edge after `frame_start`.
- Critical path: priority encode → base mux → adder → `rom_addr`. The requester's address logic feeds this same path, so keep the mux and adder shallow.

## Test plan

- **Single requester.** Req 2 only; `base[2]`=16'h1000, `req_addr`=19'h0042, `rom_data` = f(addr).
  - Required: `rom_addr`=16'h1042 the same cycle.
  - Required: `req_data[2]` = f(16'h1042) two cycles later; all other ports = 12'h000.
- **Priority conflict.** Req 1 and req 3 both read for 5 cycles.
  - Required: `grant_idx`=1 throughout and `req_data[3]`=`TRANSPARENT`.
  - Required: `conflict_count`=5 after the next `frame_start`.
- **Mask.** Req 0 and req 1 read, `req_en`=4'b1110.
  - Required: `grant_idx`=1 and `req_data[0]`=`TRANSPARENT`.
  - Required: no conflict counted.
- **Wrap and back-to-back streaming.** `base`=16'hFFF0, `req_addr` 0x10..0x1F on consecutive cycles.
  - Required: `rom_addr` 16'h0000..16'h000F.
  - Required: data returned in order with no gaps.
- **Frame boundary and saturation.**
  - Conflict coincident with `frame_start`: `conflict_count` = prior total, new `cnt`=1.
  - 70000 consecutive conflict cycles: `conflict_count`=16'hFFFF.
- **Reset mid-flight.** Assert `resetN`=0 one cycle after a granted read, release next cycle.
  - Required: the pending data is never delivered; `req_data` = `TRANSPARENT`; counters = 0.

Source files
------------

// File: rtl/sprite_rom_arbiter.sv
// sprite_rom_arbiter
//
// Shares one sprite-image ROM between N_REQ sprite draw stages. Every cycle the
// lowest-index active requester wins. Its image base plus its pixel offset goes
// to the ROM in the same cycle. The returned word is routed back to the winner
// ROM_LATENCY cycles later. Every other requester sees TRANSPARENT on that
// cycle. The block also counts contention cycles per frame.
//
// Ports
//   clk            : pixel clock
//   resetN         : asynchronous active-low reset
//   frame_start    : one-cycle pulse at the start of each frame
//   req_en         : per-requester enable mask
//   base_addr      : per-requester image base, slice i at [i*ROM_ADDR_W +: ROM_ADDR_W]
//   req_rd         : per-requester read strobe
//   req_addr       : per-requester pixel offset, slice i at [i*ADDR_W +: ADDR_W]
//   req_data       : per-requester returned pixel, slice i at [i*DATA_W +: DATA_W]
//   rom_rd         : ROM read strobe (combinational)
//   rom_addr       : ROM address (combinational)
//   rom_data       : ROM output, valid ROM_LATENCY cycles after rom_addr
//   grant_idx      : winner index this cycle, 0 when nobody reads
//   conflict_count : contention cycles counted in the previous frame
//   conflict_valid : one-cycle pulse when conflict_count updates

module sprite_rom_arbiter #(
  parameter int N_REQ       = 4,
  parameter int ADDR_W      = 19,
  parameter int ROM_ADDR_W  = 16,
  parameter int DATA_W      = 12,
  parameter int ROM_LATENCY = 2,
  parameter logic [DATA_W-1:0] TRANSPARENT = 12'h000,
  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                         clk,
  input  logic                         resetN,
  input  logic                         frame_start,
  input  logic [N_REQ-1:0]             req_en,
  input  logic [N_REQ*ROM_ADDR_W-1:0]  base_addr,
  input  logic [N_REQ-1:0]             req_rd,
  input  logic [N_REQ*ADDR_W-1:0]      req_addr,
  output logic [N_REQ*DATA_W-1:0]      req_data,
  output logic                         rom_rd,
  output logic [ROM_ADDR_W-1:0]        rom_addr,
  input  logic [DATA_W-1:0]            rom_data,
  output logic [IDX_W-1:0]             grant_idx,
  output logic [15:0]                  conflict_count,
  output logic                         conflict_valid
);

  logic [N_REQ-1:0]      act_s;
  logic [N_REQ-1:0]      gnt_vec_s;
  logic [IDX_W-1:0]      win_idx_s;
  logic                  conflict_s;
  logic [ROM_ADDR_W-1:0] sel_base_s;
  logic [ROM_ADDR_W-1:0] sel_off_s;
  logic [N_REQ-1:0]      gnt_d_s;

  logic [N_REQ-1:0]      gnt_pipe_q [ROM_LATENCY];
  logic [N_REQ-1:0]      gnt_pipe_d [ROM_LATENCY];

  logic [15:0]           cnt_q;
  logic [15:0]           cnt_d;
  logic [15:0]           cnt_inc_s;
  logic [15:0]           conflict_count_q;
  logic [15:0]           conflict_count_d;
  logic                  conflict_valid_q;
  logic                  conflict_valid_d;

  // Priority encode: isolate the lowest set bit of the active set and detect
  // two or more active requesters.
  always_comb begin
    act_s      = req_rd & req_en;
    // x & -x keeps only the lowest set bit, so lowest index wins.
    gnt_vec_s  = act_s & (~act_s + N_REQ'(1));
    // Clearing the lowest set bit leaves something only if two or more were set.
    conflict_s = |(act_s & (act_s - N_REQ'(1)));
    win_idx_s  = {IDX_W{1'b0}};
    for (int i = 0; i < N_REQ; i++) begin
      win_idx_s = win_idx_s | (IDX_W'(i) & {IDX_W{gnt_vec_s[i]}});
    end
  end

  // Base/offset select as a one-hot AND-OR so that a single adder follows it.
  // With no winner both operands are zero, which gives rom_addr = 0.
  always_comb begin
    sel_base_s = {ROM_ADDR_W{1'b0}};
    sel_off_s  = {ROM_ADDR_W{1'b0}};
    for (int i = 0; i < N_REQ; i++) begin
      sel_base_s = sel_base_s |
                   (base_addr[i*ROM_ADDR_W +: ROM_ADDR_W] & {ROM_ADDR_W{gnt_vec_s[i]}});
      sel_off_s  = sel_off_s |
                   (ROM_ADDR_W'(req_addr[i*ADDR_W +: ADDR_W]) & {ROM_ADDR_W{gnt_vec_s[i]}});
    end
  end

  assign rom_rd    = |act_s;
  assign rom_addr  = sel_base_s + sel_off_s;
  assign grant_idx = win_idx_s;

  // Grant pipeline next state: stage 0 takes the current grant, later stages shift.
  always_comb begin
    gnt_pipe_d[0] = gnt_vec_s;
    for (int s = 1; s < ROM_LATENCY; s++) begin
      gnt_pipe_d[s] = gnt_pipe_q[s-1];
    end
  end

  // Grant pipeline registers. Reset discards every read still in flight.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      for (int s = 0; s < ROM_LATENCY; s++) begin
        gnt_pipe_q[s] <= {N_REQ{1'b0}};
      end
    end else begin
      gnt_pipe_q <= gnt_pipe_d;
    end
  end

  assign gnt_d_s = gnt_pipe_q[ROM_LATENCY-1];

  // Return routing: only the requester granted ROM_LATENCY cycles ago gets rom_data.
  always_comb begin
    req_data = {(N_REQ*DATA_W){1'b0}};
    for (int i = 0; i < N_REQ; i++) begin
      req_data[i*DATA_W +: DATA_W] = gnt_d_s[i] ? rom_data : TRANSPARENT;
    end
  end

  // Contention counter next state. The frame_start cycle belongs to the new frame.
  always_comb begin
    cnt_inc_s = (cnt_q == 16'hFFFF) ? cnt_q : (cnt_q + 16'd1);
    if (frame_start) begin
      cnt_d            = {15'd0, conflict_s};
      conflict_count_d = cnt_q;
      conflict_valid_d = 1'b1;
    end else begin
      cnt_d            = conflict_s ? cnt_inc_s : cnt_q;
      conflict_count_d = conflict_count_q;
      conflict_valid_d = 1'b0;
    end
  end

  // Contention counter and reported statistics registers.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      cnt_q            <= 16'd0;
      conflict_count_q <= 16'd0;
      conflict_valid_q <= 1'b0;
    end else begin
      cnt_q            <= cnt_d;
      conflict_count_q <= conflict_count_d;
      conflict_valid_q <= conflict_valid_d;
    end
  end

  assign conflict_count = conflict_count_q;
  assign conflict_valid = conflict_valid_q;

endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// tb_sprite_rom_arbiter
//
// Directed stimulus with a behavioural reference model. A negedge process
// recomputes the arbitration from the inputs and compares every output each
// cycle. The stimulus process adds hand-computed literal expectations.

module tb_sprite_rom_arbiter;

  logic        clk = 1'b0;
  logic        resetN;
  logic        frame_start;
  logic [3:0]  req_en;
  logic [63:0] base_addr;
  logic [3:0]  req_rd;
  logic [75:0] req_addr;
  logic [47:0] req_data;
  logic        rom_rd;
  logic [15:0] rom_addr;
  logic [11:0] rom_data;
  logic [1:0]  grant_idx;
  logic [15:0] conflict_count;
  logic        conflict_valid;

  int errors = 0;
  int checks = 0;

  sprite_rom_arbiter dut (
    .clk            (clk),
    .resetN         (resetN),
    .frame_start    (frame_start),
    .req_en         (req_en),
    .base_addr      (base_addr),
    .req_rd         (req_rd),
    .req_addr       (req_addr),
    .req_data       (req_data),
    .rom_rd         (rom_rd),
    .rom_addr       (rom_addr),
    .rom_data       (rom_data),
    .grant_idx      (grant_idx),
    .conflict_count (conflict_count),
    .conflict_valid (conflict_valid)
  );

  always #5 clk = ~clk;

  // ROM contents: a scramble of the address.
  function automatic logic [11:0] f(input logic [15:0] a);
    f = a[11:0] ^ {a[15:12], a[15:12], a[15:12]} ^ 12'h5A5;
  endfunction

  // ROM with two cycles of latency.
  logic [15:0] ra1 = 16'h0000;
  logic [15:0] ra2 = 16'h0000;
  always @(posedge clk) begin
    ra1 <= rom_addr;
    ra2 <= ra1;
  end
  assign rom_data = f(ra2);

  task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, a, e, $time);
    end
  endtask

  // Reference model state.
  logic [47:0] hist_mid = 48'h0;
  logic [47:0] hist_out = 48'h0;
  int          cnt_m = 0;
  int          cc_m = 0;
  logic        cv_m = 1'b0;
  int          m_w;
  int          m_nact;
  logic [15:0] m_ea;
  logic [47:0] m_cur;

  // Compare process: derive every expected output from the inputs, then advance the model.
  always @(negedge clk) begin
    if (!resetN) begin
      hist_mid = 48'h0;
      hist_out = 48'h0;
      cnt_m    = 0;
      cc_m     = 0;
      cv_m     = 1'b0;
    end
    m_w    = -1;
    m_nact = 0;
    for (int i = 0; i < 4; i++) begin
      if (req_rd[i] && req_en[i]) begin
        m_nact++;
        if (m_w < 0) m_w = i;
      end
    end
    m_ea  = 16'h0;
    m_cur = 48'h0;
    if (m_w >= 0) begin
      m_ea = base_addr[m_w*16 +: 16] + req_addr[m_w*19 +: 16];
      m_cur[m_w*12 +: 12] = f(m_ea);
    end
    chk("rom_rd", rom_rd, (m_w >= 0));
    chk("rom_addr", rom_addr, m_ea);
    chk("grant_idx", grant_idx, (m_w < 0) ? 0 : m_w);
    chk("req_data", req_data, hist_out);
    chk("conflict_count", conflict_count, cc_m);
    chk("conflict_valid", conflict_valid, cv_m);
    if (resetN) begin
      hist_out = hist_mid;
      hist_mid = m_cur;
      if (frame_start) begin
        cc_m  = cnt_m;
        cv_m  = 1'b1;
        cnt_m = (m_nact >= 2) ? 1 : 0;
      end else begin
        cv_m = 1'b0;
        if (m_nact >= 2 && cnt_m < 65535) cnt_m = cnt_m + 1;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    req_rd      = 4'b0000;
    frame_start = 1'b0;
  endtask

  initial begin
    resetN      = 1'b0;
    frame_start = 1'b0;
    req_en      = 4'hF;
    req_rd      = 4'h0;
    base_addr   = 64'h0;
    req_addr    = 76'h0;
    tick();
    tick();
    resetN = 1'b1;

    // Single requester.
    tick();
    base_addr[32 +: 16] = 16'h1000;
    req_addr[38 +: 19]  = 19'h00042;
    req_rd = 4'b0100;
    #1 chk("single_addr", rom_addr, 16'h1042);
    tick();
    tick();
    #1 chk("single_data", req_data, 48'h0004F6000000);

    // Clear the running count.
    tick();
    frame_start = 1'b1;

    // Priority conflict: requesters 1 and 3 for five cycles.
    base_addr[16 +: 16] = 16'h2000;
    req_addr[19 +: 19]  = 19'h00005;
    base_addr[48 +: 16] = 16'h3000;
    req_addr[57 +: 19]  = 19'h00007;
    for (int k = 0; k < 5; k++) begin
      tick();
      req_rd = 4'b1010;
      #1 chk("prio_idx", grant_idx, 2'd1);
    end
    tick();
    frame_start = 1'b1;
    tick();
    #1 chk("prio_count", conflict_count, 16'd5);
    chk("prio_valid", conflict_valid, 1'b1);
    chk("prio_loser", req_data[36 +: 12], 12'h000);

    // Mask: requester 0 disabled.
    tick();
    req_en = 4'b1110;
    req_rd = 4'b0011;
    #1 chk("mask_idx", grant_idx, 2'd1);
    tick();
    req_en = 4'hF;
    frame_start = 1'b1;
    tick();
    #1 chk("mask_count", conflict_count, 16'd0);
    chk("mask_loser", req_data[0 +: 12], 12'h000);

    // Wrap and back-to-back streaming on requester 0.
    base_addr[0 +: 16] = 16'hFFF0;
    for (int k = 0; k < 16; k++) begin
      tick();
      req_rd = 4'b0001;
      req_addr[0 +: 19] = 19'h00010 + 19'(k);
      #1 chk("wrap_addr", rom_addr, 16'(k));
    end
    tick();
    tick();
    #1 chk("wrap_last", req_data[0 +: 12], 12'h5AA);

    // Conflict coincident with frame_start.
    for (int k = 0; k < 3; k++) begin
      tick();
      req_rd = 4'b0011;
    end
    tick();
    req_rd = 4'b0011;
    frame_start = 1'b1;
    tick();
    #1 chk("fb_prior", conflict_count, 16'd3);
    tick();
    frame_start = 1'b1;
    tick();
    #1 chk("fb_new", conflict_count, 16'd1);

    // Saturation.
    for (int k = 0; k < 70000; k++) begin
      tick();
      req_rd = 4'b1111;
    end
    tick();
    frame_start = 1'b1;
    tick();
    #1 chk("sat_count", conflict_count, 16'hFFFF);

    // Reset one cycle after a granted read.
    tick();
    req_rd = 4'b0100;
    tick();
    resetN = 1'b0;
    tick();
    resetN = 1'b1;
    #1 chk("rst_data", req_data, 48'h0);
    chk("rst_count", conflict_count, 16'd0);
    chk("rst_valid", conflict_valid, 1'b0);
    tick();
    #1 chk("rst_data_late", req_data, 48'h0);
    tick();
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
